// File: rtl/sd_bd_fetch.sv
// Descriptor fetch engine: reads pending BDs as four 16-bit words, hands the
// assembled source/block addresses to the transfer engine, then returns the slot.
module sd_bd_fetch #(
   parameter int BD_WIDTH      = 5,
   parameter int BD_FREE_MAX   = 8,
   parameter int RAM_MEM_WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic [BD_WIDTH-1:0]      free_bd,
   output logic                     re_s,
   input  logic                     ack_o_s,
   input  logic [RAM_MEM_WIDTH-1:0] dat_out_s,
   output logic                     a_cmp,
   output logic [31:0]              src_addr,
   output logic [31:0]              blk_addr,
   output logic                     xfer_start,
   input  logic                     xfer_done,
   input  logic                     xfer_err,
   output logic                     busy,
   output logic                     last_err,
   output logic [15:0]              done_cnt
);

   typedef enum logic [2:0] {
      IDLE,
      RD_REQ,
      RD_WAIT,
      DISPATCH,
      XFER,
      CMP1,
      CMP2,
      SETTLE
   } state_t;

   localparam logic [BD_WIDTH-1:0] FREE_MAX = BD_WIDTH'(BD_FREE_MAX);

   state_t                          state_q, state_d;
   logic [1:0]                      widx_q, widx_d;
   logic [3:0][RAM_MEM_WIDTH-1:0]   word_q, word_d;
   logic                            last_err_q, last_err_d;
   logic [15:0]                     done_cnt_q, done_cnt_d;

   logic pending;
   logic word_take;

   assign pending   = (free_bd < FREE_MAX);
   assign word_take = (state_q == RD_WAIT) && ack_o_s;

   // Each descriptor word slot captures read data only when its index is active.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_word
         assign word_d[gi] = (word_take && (widx_q == 2'(gi))) ? dat_out_s : word_q[gi];
      end
   endgenerate

   always_comb begin
      state_d    = state_q;
      widx_d     = widx_q;
      last_err_d = last_err_q;
      done_cnt_d = done_cnt_q;
      case (state_q)
         IDLE: begin
            if (en && pending) begin
               widx_d  = 2'd0;
               state_d = RD_REQ;
            end
         end
         RD_REQ:   state_d = RD_WAIT;
         RD_WAIT: begin
            if (ack_o_s) begin
               if (widx_q == 2'd3) begin
                  state_d = DISPATCH;
               end else begin
                  widx_d  = widx_q + 2'd1;
                  state_d = RD_REQ;
               end
            end
         end
         DISPATCH: state_d = XFER;
         XFER: begin
            // An error reported together with done still marks the descriptor bad.
            if (xfer_done || xfer_err) begin
               last_err_d = xfer_err;
               state_d    = CMP1;
            end
         end
         CMP1:     state_d = CMP2;
         CMP2: begin
            done_cnt_d = done_cnt_q + 16'd1;
            state_d    = SETTLE;
         end
         SETTLE:   state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         widx_q     <= 2'd0;
         word_q     <= '0;
         last_err_q <= 1'b0;
         done_cnt_q <= 16'd0;
      end else begin
         state_q    <= state_d;
         widx_q     <= widx_d;
         word_q     <= word_d;
         last_err_q <= last_err_d;
         done_cnt_q <= done_cnt_d;
      end
   end

   // Two a_cmp cycles so the count survives a host write colliding with the first.
   assign re_s       = (state_q == RD_REQ);
   assign xfer_start = (state_q == DISPATCH);
   assign a_cmp      = (state_q == CMP1) || (state_q == CMP2);
   assign busy       = (state_q != IDLE);
   assign src_addr   = {word_q[1], word_q[0]};
   assign blk_addr   = {word_q[3], word_q[2]};
   assign last_err   = last_err_q;
   assign done_cnt   = done_cnt_q;

endmodule

// File: tb/tb_sd_bd_fetch.sv
// Directed bench for sd_bd_fetch with a small BD-memory model, ack responder
// and transfer-engine responder around the DUT.
module tb_sd_bd_fetch;
   localparam int BDW = 5;

   logic            clk = 1'b0;
   logic            rst, en, re_s, ack_o_s, a_cmp, xfer_start, xfer_done, xfer_err;
   logic            busy, last_err;
   logic [BDW-1:0]  free_bd;
   logic [15:0]     dat_out_s, done_cnt;
   logic [31:0]     src_addr, blk_addr;

   always #5 clk = ~clk;

   sd_bd_fetch #(.BD_WIDTH(BDW), .BD_FREE_MAX(8), .RAM_MEM_WIDTH(16)) dut (
      .clk(clk), .rst(rst), .en(en), .free_bd(free_bd), .re_s(re_s),
      .ack_o_s(ack_o_s), .dat_out_s(dat_out_s), .a_cmp(a_cmp),
      .src_addr(src_addr), .blk_addr(blk_addr), .xfer_start(xfer_start),
      .xfer_done(xfer_done), .xfer_err(xfer_err), .busy(busy),
      .last_err(last_err), .done_cnt(done_cnt)
   );

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // BD memory model: host side writes, free count with write-priority edge detector
   logic [15:0] bd_mem [0:255];
   int          wr_ptr = 0;
   int          rd_ptr = 0;
   int          cmp_cnt = 0;
   int          wr_seen = 0;
   bit          defer = 1'b0;
   logic        cmp_prev = 1'b0;

   task automatic host_bd(input logic [15:0] w0, w1, w2, w3);
      bd_mem[(wr_ptr*4+0)%256] = w0;
      bd_mem[(wr_ptr*4+1)%256] = w1;
      bd_mem[(wr_ptr*4+2)%256] = w2;
      bd_mem[(wr_ptr*4+3)%256] = w3;
      wr_ptr++;
   endtask

   initial begin
      free_bd = BDW'(8);
      forever begin
         @(negedge clk);
         #1;
         if (rst === 1'b1) begin
            cmp_cnt  = wr_ptr;
            defer    = 1'b0;
            cmp_prev = 1'b0;
         end else begin
            if (a_cmp === 1'b1 && cmp_prev !== 1'b1) begin
               if (wr_ptr != wr_seen) defer = 1'b1;
               else cmp_cnt++;
            end else if (a_cmp === 1'b1 && defer) begin
               cmp_cnt++;
               defer = 1'b0;
            end
            cmp_prev = a_cmp;
         end
         wr_seen = wr_ptr;
         free_bd = BDW'(8 - (wr_ptr - cmp_cnt));
      end
   end

   // Read responder: ack arrives 1 + ack_dly cycles after re_s
   int ack_dly = 0;
   initial begin
      ack_o_s   = 1'b0;
      dat_out_s = 16'h0;
      @(negedge clk);
      forever begin
         if (rst === 1'b1) begin
            rd_ptr = wr_ptr * 4;
            @(negedge clk);
         end else if (re_s === 1'b1) begin
            repeat (1 + ack_dly) @(negedge clk);
            ack_o_s   = 1'b1;
            dat_out_s = bd_mem[rd_ptr%256];
            rd_ptr++;
            @(negedge clk);
            ack_o_s   = 1'b0;
            dat_out_s = 16'h0;
         end else begin
            @(negedge clk);
         end
      end
   end

   // Transfer-engine responder: mode 0 done, 1 err, 2 both
   int xfer_dly  = 0;
   int xfer_mode = 0;
   bit xfer_auto = 1'b1;
   initial begin
      xfer_done = 1'b0;
      xfer_err  = 1'b0;
      @(negedge clk);
      forever begin
         if (xfer_start === 1'b1 && xfer_auto) begin
            repeat (1 + xfer_dly) @(negedge clk);
            xfer_done = (xfer_mode != 1);
            xfer_err  = (xfer_mode != 0);
            @(negedge clk);
            xfer_done = 1'b0;
            xfer_err  = 1'b0;
         end else begin
            @(negedge clk);
         end
      end
   end

   // Monitor, sampling 2 time units after each rising edge
   int          cyc = 0, re_cnt = 0, xs_cnt = 0, cmp_cycles = 0, cmp_bad = 0, cmp_run = 0;
   int          fetch_lat = -1, busy_start = 0, xs_cyc = 0, cmp_rise_cyc = 0, re_gap = -1;
   bit          gap_arm = 1'b0;
   logic        busy_prev = 1'b0, cmp_prev_m = 1'b0;
   logic [31:0] cap_src [0:31];
   logic [31:0] cap_blk [0:31];

   initial begin
      forever begin
         @(posedge clk);
         #2;
         cyc++;
         if (busy === 1'b1 && busy_prev === 1'b0) busy_start = cyc;
         if (re_s === 1'b1) begin
            re_cnt++;
            if (gap_arm) begin
               re_gap  = cyc - cmp_rise_cyc;
               gap_arm = 1'b0;
            end
         end
         if (xfer_start === 1'b1) begin
            cap_src[xs_cnt%32] = src_addr;
            cap_blk[xs_cnt%32] = blk_addr;
            xs_cnt++;
            xs_cyc    = cyc;
            fetch_lat = cyc - busy_start;
         end
         if (a_cmp === 1'b1) begin
            cmp_cycles++;
            cmp_run++;
            if (cmp_prev_m !== 1'b1) begin
               cmp_rise_cyc = cyc;
               gap_arm      = 1'b1;
            end
         end else if (cmp_prev_m === 1'b1) begin
            if (cmp_run != 2) cmp_bad++;
            cmp_run = 0;
         end
         busy_prev  = busy;
         cmp_prev_m = a_cmp;
      end
   end

   task automatic run_until_quiet(input int budget);
      int  n = 0;
      int  idle_run = 0;
      bit  seen_busy = 1'b0;
      while (n < budget && !(seen_busy && idle_run >= 3)) begin
         @(negedge clk);
         n++;
         if (busy === 1'b1) begin
            seen_busy = 1'b1;
            idle_run  = 0;
         end else begin
            idle_run++;
         end
      end
      chk("quiet_timeout", {31'd0, (seen_busy && idle_run >= 3)}, 32'd1);
   endtask

   task automatic wait_xs(input int target, input int budget);
      int n = 0;
      while (n < budget && xs_cnt < target) begin
         @(negedge clk);
         n++;
      end
      chk("xfer_start_timeout", {31'd0, (xs_cnt >= target)}, 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int r0, x0, c0, n;
      rst = 1'b1;
      en  = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_re_s", {31'd0, re_s}, 32'd0);
      chk("rst_a_cmp", {31'd0, a_cmp}, 32'd0);
      chk("rst_xfer_start", {31'd0, xfer_start}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_last_err", {31'd0, last_err}, 32'd0);
      chk("rst_done_cnt", {16'd0, done_cnt}, 32'd0);
      chk("rst_src", src_addr, 32'd0);
      chk("rst_blk", blk_addr, 32'd0);

      // Single descriptor, nominal ack
      en = 1'b1;
      r0 = re_cnt; x0 = xs_cnt; c0 = cmp_cycles;
      host_bd(16'h1000, 16'h2000, 16'h0040, 16'h0000);
      run_until_quiet(200);
      chk("t1_re_count", re_cnt - r0, 32'd4);
      chk("t1_xs_count", xs_cnt - x0, 32'd1);
      chk("t1_src_at_start", cap_src[x0%32], 32'h2000_1000);
      chk("t1_blk_at_start", cap_blk[x0%32], 32'h0000_0040);
      chk("t1_fetch_cycles", fetch_lat, 32'd8);
      chk("t1_cmp_after_done", cmp_rise_cyc - xs_cyc, 32'd2);
      chk("t1_cmp_cycles", cmp_cycles - c0, 32'd2);
      chk("t1_free_bd", {27'd0, free_bd}, 32'd8);
      chk("t1_done_cnt", {16'd0, done_cnt}, 32'd1);
      chk("t1_last_err", {31'd0, last_err}, 32'd0);
      chk("t1_src_hold", src_addr, 32'h2000_1000);

      // Slow ack and delayed done
      ack_dly = 5; xfer_dly = 3;
      r0 = re_cnt; x0 = xs_cnt;
      host_bd(16'hBEEF, 16'hDEAD, 16'h1234, 16'h5678);
      run_until_quiet(400);
      chk("t2_re_count", re_cnt - r0, 32'd4);
      chk("t2_src", cap_src[x0%32], 32'hDEAD_BEEF);
      chk("t2_blk", cap_blk[x0%32], 32'h5678_1234);
      chk("t2_fetch_cycles", fetch_lat, 32'd28);
      chk("t2_cmp_after_done", cmp_rise_cyc - xs_cyc, 32'd5);
      chk("t2_done_cnt", {16'd0, done_cnt}, 32'd2);
      ack_dly = 0; xfer_dly = 0;

      // Transfer error, then error together with done
      xfer_mode = 1;
      c0 = cmp_cycles;
      host_bd(16'h0001, 16'h0002, 16'h0003, 16'h0004);
      run_until_quiet(200);
      chk("t3_last_err", {31'd0, last_err}, 32'd1);
      chk("t3_cmp_cycles", cmp_cycles - c0, 32'd2);
      chk("t3_done_cnt", {16'd0, done_cnt}, 32'd3);
      chk("t3_blk", blk_addr, 32'h0004_0003);
      xfer_mode = 2;
      host_bd(16'h0011, 16'h0022, 16'h0033, 16'h0044);
      run_until_quiet(200);
      chk("t3b_last_err_both", {31'd0, last_err}, 32'd1);
      chk("t3b_done_cnt", {16'd0, done_cnt}, 32'd4);
      xfer_mode = 0;

      // Collision: host completes a BD in the first a_cmp cycle
      x0 = xs_cnt;
      host_bd(16'hA0A0, 16'h0A0A, 16'h0001, 16'h0000);
      n = 0;
      while (n < 200 && a_cmp !== 1'b1) begin
         @(negedge clk);
         n++;
      end
      chk("t4_cmp_seen", {31'd0, a_cmp}, 32'd1);
      host_bd(16'hB0B0, 16'h0B0B, 16'h0002, 16'h0000);
      wait_xs(x0 + 2, 200);
      chk("t4_free_during_b", {27'd0, free_bd}, 32'd7);
      chk("t4_cmp_to_re_gap", re_gap, 32'd4);
      run_until_quiet(200);
      chk("t4_src_a", cap_src[x0%32], 32'h0A0A_A0A0);
      chk("t4_src_b", cap_src[(x0+1)%32], 32'h0B0B_B0B0);
      chk("t4_free_bd", {27'd0, free_bd}, 32'd8);
      chk("t4_done_cnt", {16'd0, done_cnt}, 32'd6);
      chk("t4_last_err", {31'd0, last_err}, 32'd0);

      // Full queue of 8 descriptors
      en = 1'b0;
      for (int i = 0; i < 8; i++)
         host_bd(16'h0100 + 16'(i), 16'hC000, 16'(i * 16), 16'h0001);
      @(negedge clk);
      @(negedge clk);
      chk("t5_free_full", {27'd0, free_bd}, 32'd0);
      r0 = re_cnt; x0 = xs_cnt;
      en = 1'b1;
      run_until_quiet(1000);
      for (int i = 0; i < 8; i++)
         chk($sformatf("t5_src_%0d", i), cap_src[(x0+i)%32], {16'hC000, 16'h0100 + 16'(i)});
      chk("t5_blk_7", cap_blk[(x0+7)%32], 32'h0001_0070);
      chk("t5_re_count", re_cnt - r0, 32'd32);
      chk("t5_free_bd", {27'd0, free_bd}, 32'd8);
      chk("t5_done_cnt", {16'd0, done_cnt}, 32'd14);
      chk("t5_cmp_len_bad", cmp_bad, 32'd0);
      r0 = re_cnt;
      repeat (10) @(negedge clk);
      chk("t5_no_refetch", re_cnt - r0, 32'd0);

      // Reset while in XFER
      xfer_auto = 1'b0;
      x0 = xs_cnt; c0 = cmp_cycles;
      host_bd(16'h5555, 16'h6666, 16'h7777, 16'h8888);
      wait_xs(x0 + 1, 200);
      repeat (3) @(negedge clk);
      chk("t6_busy_in_xfer", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("t6_busy", {31'd0, busy}, 32'd0);
      chk("t6_a_cmp", {31'd0, a_cmp}, 32'd0);
      chk("t6_src", src_addr, 32'd0);
      chk("t6_blk", blk_addr, 32'd0);
      chk("t6_done_cnt", {16'd0, done_cnt}, 32'd0);
      en  = 1'b0;
      rst = 1'b0;
      xfer_auto = 1'b1;
      repeat (3) @(negedge clk);
      chk("t6_no_cmp", cmp_cycles - c0, 32'd0);

      // en low with a descriptor pending: no fetch until enabled
      r0 = re_cnt;
      host_bd(16'h0F0F, 16'hF0F0, 16'h0009, 16'h0000);
      repeat (20) @(negedge clk);
      chk("t7_no_fetch", re_cnt - r0, 32'd0);
      chk("t7_idle", {31'd0, busy}, 32'd0);
      chk("t7_free_pending", {27'd0, free_bd}, 32'd7);
      en = 1'b1;
      run_until_quiet(200);
      chk("t7_src", src_addr, 32'hF0F0_0F0F);
      chk("t7_done_cnt", {16'd0, done_cnt}, 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
